// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - instruction memory loaded from a byte stream, registered fetch port
// Words are assembled MSB-first from the load stream; fetches past prog_len return NOP_WORD.

module imem_stream_loader #(
    parameter int                 ADDR_W   = 8,
    parameter int                 INSTR_W  = 16,
    parameter int                 BYTE_W   = 8,
    parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load_start,
    input  logic                i_load_end,
    input  logic                i_load_valid,
    input  logic [BYTE_W-1:0]   i_load_data,
    output logic                o_load_ready,
    output logic                o_load_err,
    output logic                o_full,
    input  logic                i_fetch_req,
    input  logic [ADDR_W-1:0]   i_pc,
    output logic [INSTR_W-1:0]  o_instr,
    output logic                o_instr_valid,
    output logic                o_busy,
    output logic [ADDR_W:0]     o_prog_len
);

    localparam int BPW   = INSTR_W / BYTE_W;
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [ADDR_W:0]   FULL_LEN  = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              r_state;
    logic [INSTR_W-1:0]  r_mem [DEPTH];
    logic [INSTR_W-1:0]  r_asm;
    logic [CNT_W-1:0]    r_bcnt;
    logic [ADDR_W-1:0]   r_wptr;
    logic [ADDR_W:0]     r_prog_len;
    logic                r_load_err;
    logic [INSTR_W-1:0]  r_instr;
    logic                r_instr_valid;

    logic                w_accept;
    logic                w_word_done;
    logic [INSTR_W-1:0]  w_asm_next;
    logic [CNT_W-1:0]    w_bcnt_next;
    logic                w_pc_hit;

    assign o_full        = (r_prog_len == FULL_LEN);
    assign o_load_ready  = (r_state == ST_LOAD) && !o_full;
    assign o_busy        = (r_state == ST_LOAD);
    assign o_load_err    = r_load_err;
    assign o_prog_len    = r_prog_len;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_instr_valid;

    // A restart pulse wins over a byte offered in the same cycle.
    assign w_accept    = i_load_valid && o_load_ready && !i_load_start;
    assign w_word_done = w_accept && (r_bcnt == LAST_BYTE);
    assign w_asm_next  = INSTR_W'({r_asm, i_load_data});
    assign w_pc_hit    = ({1'b0, i_pc} < r_prog_len);

    always_comb begin
        w_bcnt_next = r_bcnt;
        if (w_accept) begin
            w_bcnt_next = w_word_done ? '0 : r_bcnt + 1'b1;
        end
    end

    // Memory has no reset; stale contents are hidden behind prog_len.
    always_ff @(posedge i_clk) begin
        if (w_word_done) begin
            r_mem[r_wptr] <= w_asm_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_asm         <= '0;
            r_bcnt        <= '0;
            r_wptr        <= '0;
            r_prog_len    <= '0;
            r_load_err    <= 1'b0;
            r_instr       <= NOP_WORD;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            if (i_load_start) begin
                r_state    <= ST_LOAD;
                r_bcnt     <= '0;
                r_wptr     <= '0;
                r_prog_len <= '0;
                r_load_err <= 1'b0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (i_fetch_req) begin
                            r_instr       <= w_pc_hit ? r_mem[i_pc] : NOP_WORD;
                            r_instr_valid <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (w_accept) begin
                            r_asm  <= w_asm_next;
                            r_bcnt <= w_bcnt_next;
                        end
                        if (w_word_done) begin
                            r_prog_len <= r_prog_len + 1'b1;
                            if (r_wptr != LAST_ADDR) begin
                                r_wptr <= r_wptr + 1'b1;
                            end
                        end
                        // Completeness is judged after this cycle's byte is counted.
                        if (i_load_end) begin
                            r_state <= ST_RUN;
                            r_bcnt  <= '0;
                            if (w_bcnt_next != '0) begin
                                r_load_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - randomized bench for imem_stream_loader against a program-image model

module tb_imem_stream_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_end = 1'b0;
    logic        load_valid = 1'b0;
    logic [7:0]  load_data = '0;
    logic        load_ready;
    logic        load_err;
    logic        full;
    logic        fetch_req = 1'b0;
    logic [7:0]  pc = '0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        busy;
    logic [8:0]  prog_len;

    int n_cmp = 0;
    int n_fail = 0;

    imem_stream_loader dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_load_start(load_start), .i_load_end(load_end),
        .i_load_valid(load_valid), .i_load_data(load_data),
        .o_load_ready(load_ready), .o_load_err(load_err), .o_full(full),
        .i_fetch_req(fetch_req), .i_pc(pc),
        .o_instr(instr), .o_instr_valid(instr_valid),
        .o_busy(busy), .o_prog_len(prog_len)
    );

    always #5 clk = ~clk;

    // Program-image model: a list of loaded words plus the bytes of the word in progress.
    logic [15:0] m_mem [256];
    int          m_len = 0;
    bit          m_loading = 0;
    bit          m_err = 0;
    logic [7:0]  m_pend [$];
    logic [15:0] m_instr = 16'h0000;
    bit          m_valid = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_len = 0; m_loading = 0; m_err = 0; m_pend.delete();
            m_instr = 16'h0000; m_valid = 0;
        end else begin
            m_valid = 0;
            if (load_start) begin
                m_loading = 1; m_len = 0; m_err = 0; m_pend.delete();
            end else if (!m_loading) begin
                if (fetch_req) begin
                    m_instr = (int'(pc) < m_len) ? m_mem[pc] : 16'h0000;
                    m_valid = 1;
                end
            end else begin
                if (load_valid && m_len < 256) begin
                    m_pend.push_back(load_data);
                    if (m_pend.size() == 2) begin
                        m_mem[m_len] = {m_pend[0], m_pend[1]};
                        m_len++;
                        m_pend.delete();
                    end
                end
                if (load_end) begin
                    if (m_pend.size() != 0) m_err = 1;
                    m_pend.delete();
                    m_loading = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("instr", 32'(instr), 32'(m_instr));
        chk("prog_len", 32'(prog_len), 32'(m_len));
        chk("load_err", 32'(load_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_loading));
        chk("full", 32'(full), 32'(m_len == 256));
        chk("load_ready", 32'(load_ready), 32'(m_loading && m_len < 256));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        load_valid = 1'b1; load_data = b;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic start_load();
        load_start = 1'b1; tick(); load_start = 1'b0;
    endtask

    task automatic end_load();
        load_end = 1'b1; tick(); load_end = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] a, input logic [15:0] exp, input string name);
        fetch_req = 1'b1; pc = a;
        tick();
        fetch_req = 1'b0;
        chk({name, "_valid"}, 32'(instr_valid), 32'd1);
        chk(name, 32'(instr), 32'(exp));
    endtask

    logic [7:0]  prog1 [8];
    logic [15:0] lit [4];
    logic [7:0]  last_b [2];
    int          nb;

    initial begin
        prog1[0] = 8'h35; prog1[1] = 8'h05; prog1[2] = 8'h15; prog1[3] = 8'h50;
        prog1[4] = 8'h45; prog1[5] = 8'h02; prog1[6] = 8'h00; prog1[7] = 8'h00;
        lit[0] = 16'h3505; lit[1] = 16'h1550; lit[2] = 16'h4502; lit[3] = 16'h0000;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_instr", 32'(instr), 32'h0);
        chk("reset_prog_len", 32'(prog_len), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        fetch(8'd0, 16'h0000, "empty_fetch");
        tick();
        chk("valid_one_pulse", 32'(instr_valid), 32'd0);

        start_load();
        for (int i = 0; i < 8; i++) send(prog1[i]);
        end_load();
        for (int k = 0; k < 4; k++) begin
            fetch_req = 1'b1; pc = 8'(k);
            tick();
            chk("b2b_valid", 32'(instr_valid), 32'd1);
            chk("b2b_instr", 32'(instr), 32'(lit[k]));
        end
        fetch_req = 1'b0;
        chk("prog1_len", 32'(prog_len), 32'd4);
        chk("prog1_err", 32'(load_err), 32'd0);
        fetch(8'd4, 16'h0000, "past_end");
        fetch(8'd255, 16'h0000, "pc255_nop");

        start_load();
        send(8'hAA); send(8'hBB); send(8'hCC);
        end_load();
        chk("partial_len", 32'(prog_len), 32'd1);
        chk("partial_err", 32'(load_err), 32'd1);
        fetch(8'd0, 16'hAABB, "partial_word0");
        fetch(8'd1, 16'h0000, "partial_word1");
        start_load();
        chk("err_cleared", 32'(load_err), 32'd0);
        fetch_req = 1'b1; pc = 8'd0;
        tick();
        fetch_req = 1'b0;
        chk("load_fetch_valid", 32'(instr_valid), 32'd0);
        chk("load_fetch_busy", 32'(busy), 32'd1);
        end_load();
        load_start = 1'b1; fetch_req = 1'b1; pc = 8'd0;
        tick();
        load_start = 1'b0; fetch_req = 1'b0;
        chk("start_beats_fetch", 32'(instr_valid), 32'd0);
        chk("start_to_load", 32'(busy), 32'd1);
        end_load();

        for (int it = 0; it < 8; it++) begin
            start_load();
            nb = $urandom_range(0, 30);
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    fetch_req = 1'($urandom); pc = 8'($urandom);
                    tick();
                end
                fetch_req = 1'b0;
                load_valid = 1'b1; load_data = 8'($urandom);
                load_end = (i == nb - 1) && ($urandom_range(0, 3) == 0);
                tick();
                load_valid = 1'b0;
                if (load_end) begin
                    load_end = 1'b0;
                    nb = -1;
                end
            end
            if (nb != -1) end_load();
            repeat (20) begin
                fetch_req = 1'($urandom);
                pc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 18));
                tick();
            end
            fetch_req = 1'b0;
        end

        start_load();
        load_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            load_data = 8'($urandom_range(1, 254));
            if (i >= 510) last_b[i - 510] = load_data;
            tick();
        end
        load_data = 8'hFF;
        repeat (3) tick();
        chk("full_flag", 32'(full), 32'd1);
        chk("full_ready", 32'(load_ready), 32'd0);
        chk("full_len", 32'(prog_len), 32'd256);
        load_valid = 1'b0;
        end_load();
        fetch(8'd255, {last_b[0], last_b[1]}, "full_last_word");

        start_load();
        for (int i = 0; i < 5; i++) send(8'($urandom_range(1, 254)));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_prog_len", 32'(prog_len), 32'd0);
        chk("arst_instr", 32'(instr), 32'h0);
        #4;
        rst_n = 1'b1;
        tick();
        fetch(8'd0, 16'h0000, "post_arst_fetch");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised instruction memory with a byte-stream programming port and a registered fetch port.
- Words are written at run time through a valid/ready byte interface, not preloaded.
- Sits between the boot/debug host, which drives the load stream, and the core's fetch stage, which presents the PC.
- Tracks program length; fetches past the loaded program return a NOP.

Parameters:
ADDR_W, 8, address (PC) width; DEPTH = 2**ADDR_W words.
INSTR_W, 16, instruction word width; must be an integer multiple of BYTE_W.
BYTE_W, 8, load-stream symbol width; BPW = INSTR_W/BYTE_W (derived localparam).
NOP_WORD, 0, word returned for unloaded addresses and driven on instr after reset.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
load_start  input  1  single-cycle pulse: begin new program load
load_end  input  1  single-cycle pulse: finish load, return to RUN
load_valid  input  1  byte on load_data is valid
load_data  input  BYTE_W  program byte, most-significant byte of each word first
load_ready  output  1  block accepts a byte this cycle
load_err  output  1  sticky: last load ended on a partial word
full  output  1  prog_len == DEPTH
fetch_req  input  1  fetch request for address pc
pc  input  ADDR_W  fetch address
instr  output  INSTR_W  fetched instruction (registered)
instr_valid  output  1  instr updated this cycle (one-cycle pulse)
busy  output  1  high in LOAD state
prog_len  output  ADDR_W+1  number of words loaded

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; instr=NOP_WORD; instr_valid=0; prog_len=0; load_err=0.
  - Write pointer and byte counter cleared.
  - Memory array not reset; unloaded words are masked by prog_len.
- States: RUN, LOAD.
- RUN -> LOAD on load_start. Clears prog_len, write pointer, byte counter and load_err.
- LOAD -> LOAD on load_start: restart, same clearing.
- LOAD -> RUN on load_end when load_start is low.
  - If the byte counter is non-zero, the partial word is discarded and load_err is set.
  - load_err stays set until the next load_start.
- load_start has priority over load_end and over fetch_req in the same cycle. A dropped fetch produces no instr_valid.
- load_ready = (state==LOAD) && !full. It is combinational from registered state only, with no dependence on load_valid.
- A byte transfers when load_valid && load_ready.
  - The byte shifts into an assembly register, MSB-first, and the byte counter increments.
  - On the BPW-th byte, the assembled word is written to mem[wptr] at that same clock edge.
  - wptr and prog_len increment at that edge; the byte counter returns to 0.
- Full: once prog_len==DEPTH, full=1 and load_ready=0. Further bytes are not accepted and memory is not overwritten. The write pointer does not wrap.
- A byte transfer in the same cycle as load_end is accepted first, then the state exits. The completeness check uses the updated byte counter.
- Fetch in RUN: fetch_req sampled at edge N.
  - At edge N+1, instr = mem[pc] if pc < prog_len, else NOP_WORD; instr_valid=1 for that cycle only.
  - Back-to-back fetch_req gives one word per cycle.
  - Without fetch_req, instr holds its last value and instr_valid=0.
- Fetch in LOAD: fetch_req is ignored, instr holds its value, instr_valid=0, busy=1.
- Reset asserted mid-load: immediate return to RUN with prog_len=0. Previously loaded words are unreachable (they return NOP_WORD).
- Width rules:
  - prog_len is ADDR_W+1 bits so it can hold DEPTH.
  - The pc vs prog_len comparison is unsigned, with pc zero-extended.

Test Plan:
- Reset, then fetch pc=0 -> instr=0x0000, instr_valid pulses once; prog_len=0.
- load_start; stream 35 05 15 50 45 02 00 00; load_end; fetch pc=0..3 back-to-back -> 0x3505, 0x1550, 0x4502, 0x0000 on consecutive cycles; prog_len=4; load_err=0.
- After that load, fetch pc=4 and pc=255 -> 0x0000 (NOP_WORD); load 3 bytes AA BB CC then load_end -> prog_len=1, mem[0]=0xAABB, load_err=1; next load_start clears load_err.
- Stream 512 bytes with load_valid held high -> full=1 and load_ready=0 after 256th word; extra byte 0xFF held -> not accepted; fetch pc=255 returns last loaded word.
- In LOAD, assert fetch_req with pc=0 -> instr_valid stays 0, busy=1; assert load_start together with fetch_req in RUN -> no instr_valid, state=LOAD.
- Assert rst_n=0 asynchronously after 2 words loaded, mid-word -> busy=0, prog_len=0, instr=0x0000 immediately; subsequent fetch pc=0 -> 0x0000.
